// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared XLEN, RV32M funct3 encodings and divider state type
package mul_div_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [2:0] CTRL_DIV  = 3'b100;
  localparam logic [2:0] CTRL_DIVU = 3'b101;
  localparam logic [2:0] CTRL_REM  = 3'b110;
  localparam logic [2:0] CTRL_REMU = 3'b111;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring division step {rem_in, quo_in, divisor} -> {rem_out, quo_out}
module div_step
  import mul_div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] w_part;
  logic          w_ge;
  assign w_part = {rem_in, quo_in[XLEN-1]};
  assign w_ge   = w_part >= {1'b0, divisor};
  always_comb begin
    rem_out = w_ge ? XLEN'(w_part - {1'b0, divisor}) : w_part[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], w_ge};
  end
endmodule

// File: rtl/iterative_divider.sv
// iterative_divider: radix-2 RV32M DIV/DIVU/REM/REMU; in start/dividend/divisor/MUL_DIV_ctrl, out DIV_out/DIV_done/DIV_busy
module iterative_divider
  import mul_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [2:0]      MUL_DIV_ctrl,
  output logic [XLEN-1:0] DIV_out,
  output logic            DIV_done,
  output logic            DIV_busy
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  div_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_rem, r_quo, r_dvsr;
  logic             r_qneg, r_rneg, r_want_rem;
  logic             w_signed, w_sd, w_ss, w_want_rem, w_special;
  logic [XLEN-1:0]  w_abs_a, w_abs_b, w_special_val, w_rem_nx, w_quo_nx, w_fix;
  assign w_signed   = ~MUL_DIV_ctrl[0];
  assign w_want_rem = MUL_DIV_ctrl[1];
  assign w_sd       = w_signed & dividend[XLEN-1];
  assign w_ss       = w_signed & divisor[XLEN-1];
  assign w_abs_a    = w_sd ? -dividend : dividend;
  assign w_abs_b    = w_ss ? -divisor : divisor;
  // divide-by-zero and signed overflow bypass the iteration entirely
  assign w_special  = (divisor == '0) | (w_signed & (dividend == INT_MIN) & (&divisor));
  assign w_special_val = (divisor == '0) ? (w_want_rem ? dividend : '1)
                                         : (w_want_rem ? '0 : INT_MIN);
  assign w_fix = r_want_rem ? (r_rneg ? -r_rem : r_rem) : (r_qneg ? -r_quo : r_quo);
  div_step u_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_dvsr),
    .rem_out (w_rem_nx),
    .quo_out (w_quo_nx)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_want_rem <= 1'b0;
      DIV_out    <= '0;
      DIV_done   <= 1'b0;
      DIV_busy   <= 1'b0;
    end else begin
      DIV_done <= 1'b0;
      case (r_state)
        IDLE: if (start && MUL_DIV_ctrl[2]) begin
          r_dvsr     <= w_abs_b;
          r_qneg     <= w_sd ^ w_ss;
          r_rneg     <= w_sd;
          r_want_rem <= w_want_rem;
          r_count    <= '0;
          r_rem      <= '0;
          r_quo      <= w_abs_a;
          DIV_busy   <= 1'b1;
          if (w_special) begin
            DIV_out  <= w_special_val;
            DIV_done <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_rem   <= w_rem_nx;
          r_quo   <= w_quo_nx;
          r_count <= r_count + 1'b1;
          if (r_count == CNT_W'(XLEN-1)) r_state <= FIX;
        end
        FIX: begin
          DIV_out  <= w_fix;
          DIV_done <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          DIV_busy <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// tb_iterative_divider: directed vector table, multi-cycle corner sequences and a random sweep against a reference model
module tb_iterative_divider;
  import mul_div_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] dividend = '0, divisor = '0;
  logic [2:0]  MUL_DIV_ctrl = '0;
  logic [31:0] DIV_out;
  logic        DIV_done, DIV_busy;
  int n_cmp = 0, n_bad = 0;
  iterative_divider dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .MUL_DIV_ctrl (MUL_DIV_ctrl),
    .DIV_out      (DIV_out),
    .DIV_done     (DIV_done),
    .DIV_busy     (DIV_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[16];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    MUL_DIV_ctrl = c;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    MUL_DIV_ctrl = 3'($urandom);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (DIV_done) begin
        lat = k;
        res = DIV_out;
      end
    end
  endtask
  function automatic logic [31:0] ref_div(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return c[1] ? a : 32'hFFFF_FFFF;
    if (!c[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return c[1] ? 32'h0 : 32'h8000_0000;
      return c[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return c[1] ? a % b : a / b;
  endfunction
  function automatic logic [31:0] pick();
    logic [31:0] s[5];
    s = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0: return s[$urandom_range(0, 4)];
      1: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  c;
    int          lat;
    logic        ok;
    vecs[0]  = '{CTRL_DIVU, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{CTRL_REMU, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{CTRL_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{CTRL_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{CTRL_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[5]  = '{CTRL_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{CTRL_REMU, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[7]  = '{CTRL_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[8]  = '{CTRL_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vecs[9]  = '{CTRL_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          34};
    vecs[10] = '{CTRL_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
    vecs[11] = '{CTRL_DIV,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[12] = '{CTRL_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vecs[13] = '{CTRL_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1};
    vecs[14] = '{CTRL_DIV,  32'd0,          32'hFFFF_FFFD,  32'd0,          34};
    vecs[15] = '{CTRL_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34};
    repeat (2) @(negedge clk);
    check("reset DIV_out", DIV_out, 32'h0);
    check("reset DIV_done", 32'(DIV_done), 32'h0);
    check("reset DIV_busy", 32'(DIV_busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d done width", i), 32'(DIV_done), 32'h0);
      check($sformatf("vec%0d idle busy", i), 32'(DIV_busy), 32'h0);
    end
    // ctrl[2]=0 is not a divide and must leave the unit idle
    @(negedge clk);
    MUL_DIV_ctrl = 3'b011;
    dividend = 32'd10;
    divisor = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (DIV_busy || DIV_done) ok = 1'b0;
    end
    check("non-div ctrl stays idle", 32'(ok), 32'h1);
    // restart while busy and again in the done cycle are both ignored
    @(negedge clk);
    MUL_DIV_ctrl = CTRL_DIVU;
    dividend = 32'd1000;
    divisor = 32'd10;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    ok = 1'b1;
    res = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (!DIV_busy) ok = 1'b0;
      if (DIV_done) begin
        lat = k;
        res = DIV_out;
      end
      start = (k == 10) || DIV_done;
      dividend = 32'd77;
      divisor = 32'd7;
    end
    check("busy restart result", res, 32'd100);
    check("busy restart latency", 32'(lat), 32'd34);
    check("busy held high", 32'(ok), 32'h1);
    @(negedge clk);
    start = 1'b0;
    check("done-cycle start ignored busy", 32'(DIV_busy), 32'h0);
    repeat (3) @(negedge clk);
    check("done-cycle start ignored done", 32'(DIV_done), 32'h0);
    check("DIV_out holds in idle", DIV_out, 32'd100);
    // async reset in the middle of an iteration
    MUL_DIV_ctrl = CTRL_DIV;
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    check("busy before reset", 32'(DIV_busy), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("mid reset DIV_busy", 32'(DIV_busy), 32'h0);
    check("mid reset DIV_done", 32'(DIV_done), 32'h0);
    check("mid reset DIV_out", DIV_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_op(CTRL_DIVU, 32'd9, 32'd3, res, lat);
    check("post reset result", res, 32'd3);
    check("post reset latency", 32'(lat), 32'd34);
    for (int n = 0; n < 1500; n++) begin
      c = 3'b100 | 3'($urandom_range(0, 3));
      a = pick();
      b = pick();
      do_op(c, a, b, res, lat);
      check($sformatf("rand%0d c=%b a=%h b=%h result", n, c, a, b), res, ref_div(c, a, b));
      check($sformatf("rand%0d latency", n), 32'(lat),
            (b == 0 || (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : 32'd34);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
